// File: rtl/video_stream_pkg.sv
// Shared types and field layout for the video stream sink.
// RGB beats arrive as 24-bit {R,G,B}; they leave as 32-bit {R,G,B,A}.
package video_stream_pkg;

  localparam int PIX_W  = 24;
  localparam int RGBA_W = 32;

  localparam int PIX_R_LSB = 16;
  localparam int PIX_G_LSB = 8;
  localparam int PIX_B_LSB = 0;

  localparam int RGBA_R_LSB = 24;
  localparam int RGBA_G_LSB = 16;
  localparam int RGBA_B_LSB = 8;
  localparam int RGBA_A_LSB = 0;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    RECEIVE  = 2'd1,
    DRAIN    = 2'd2
  } sink_state_t;

  function automatic logic [RGBA_W-1:0] to_rgba(input logic [PIX_W-1:0] pix,
                                                input logic [7:0]       alpha);
    logic [RGBA_W-1:0] o;
    o = '0;
    o[RGBA_R_LSB +: 8] = pix[PIX_R_LSB +: 8];
    o[RGBA_G_LSB +: 8] = pix[PIX_G_LSB +: 8];
    o[RGBA_B_LSB +: 8] = pix[PIX_B_LSB +: 8];
    o[RGBA_A_LSB +: 8] = alpha;
    return o;
  endfunction

endpackage

// File: rtl/video_pixel_fifo.sv
// Synchronous show-ahead FIFO; the head entry is visible on rd_data while !empty.
// DEPTH must be a power of two so the pointers wrap for free.
module video_pixel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Data reads as zero when nothing is queued so the output is clean out of reset.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/video_stream_sink.sv
// Frame-checking sink: takes SOP/EOP-delimited RGB beats, tracks pixel position,
// queues pixels as RGBA and flags correctly or incorrectly sized frames.
module video_stream_sink
  import video_stream_pkg::*;
#(
  parameter int         FRAME_WIDTH  = 320,
  parameter int         FRAME_HEIGHT = 240,
  parameter logic [7:0] ALPHA        = 8'hFF,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [PIX_W-1:0]  sink_data,
  input  logic              sink_startofpacket,
  input  logic              sink_endofpacket,
  input  logic              sink_valid,
  output logic              sink_ready,
  output logic [RGBA_W-1:0] rgba_data,
  output logic              rgba_valid,
  input  logic              rgba_ready,
  output logic              stream_endofpacket,
  output logic              frame_done,
  output logic              frame_error
);

  localparam int XW = (FRAME_WIDTH  > 1) ? $clog2(FRAME_WIDTH)  : 1;
  localparam int YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_HEIGHT - 1);

  sink_state_t   state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          run;
  logic          fifo_full;
  logic          fifo_empty;

  logic          accept;
  logic          pix_beat;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          at_last;

  // run holds sink_ready low for the reset cycles and releases it afterwards.
  assign sink_ready = run && !fifo_full;
  assign accept     = sink_valid && sink_ready;
  assign rgba_valid = !fifo_empty;

  // An SOP beat always restarts at (0,0); otherwise only RECEIVE beats are pixels.
  always_comb begin
    pix_beat = accept && (sink_startofpacket || (state == RECEIVE));
    px       = sink_startofpacket ? '0 : x;
    py       = sink_startofpacket ? '0 : y;
    at_last  = (px == X_LAST) && (py == Y_LAST);
  end

  video_pixel_fifo #(
    .WIDTH (RGBA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .wr_en   (pix_beat),
    .wr_data (to_rgba(sink_data, ALPHA)),
    .rd_en   (rgba_ready),
    .rd_data (rgba_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state              <= WAIT_SOP;
      x                  <= '0;
      y                  <= '0;
      run                <= 1'b0;
      stream_endofpacket <= 1'b0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
    end else begin
      run                <= 1'b1;
      stream_endofpacket <= accept && sink_endofpacket;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
      if (pix_beat) begin
        // A fresh SOP while a frame is still open abandons the old one.
        if (sink_startofpacket && (state == RECEIVE)) frame_error <= 1'b1;
        if (sink_endofpacket) begin
          if (at_last) frame_done  <= 1'b1;
          else         frame_error <= 1'b1;
          state <= WAIT_SOP;
          x     <= '0;
          y     <= '0;
        end else if (at_last) begin
          frame_error <= 1'b1;
          state       <= DRAIN;
          x           <= '0;
          y           <= '0;
        end else begin
          state <= RECEIVE;
          if (px == X_LAST) begin
            x <= '0;
            y <= py + 1'b1;
          end else begin
            x <= px + 1'b1;
            y <= py;
          end
        end
      end else if (accept && (state == DRAIN) && sink_endofpacket) begin
        state <= WAIT_SOP;
      end
    end
  end

endmodule

// File: tb/tb_video_stream_sink.sv
// Directed bench for video_stream_sink (4x2 frames, 4-entry buffer) with a
// beat-index frame model and per-cycle output comparison.
module tb_video_stream_sink;

  localparam int         W     = 4;
  localparam int         H     = 2;
  localparam int         D     = 4;
  localparam int         N     = W * H;
  localparam logic [7:0] ALPHA = 8'hFF;

  logic        clk = 1'b0;
  logic        reset_reset_n;
  logic [23:0] sink_data;
  logic        sink_startofpacket;
  logic        sink_endofpacket;
  logic        sink_valid;
  logic        sink_ready;
  logic [31:0] rgba_data;
  logic        rgba_valid;
  logic        rgba_ready;
  logic        stream_endofpacket;
  logic        frame_done;
  logic        frame_error;

  always #5 clk = ~clk;

  video_stream_sink #(
    .FRAME_WIDTH  (W),
    .FRAME_HEIGHT (H),
    .ALPHA        (ALPHA),
    .FIFO_DEPTH   (D)
  ) dut (
    .clk_clk            (clk),
    .reset_reset_n      (reset_reset_n),
    .sink_data          (sink_data),
    .sink_startofpacket (sink_startofpacket),
    .sink_endofpacket   (sink_endofpacket),
    .sink_valid         (sink_valid),
    .sink_ready         (sink_ready),
    .rgba_data          (rgba_data),
    .rgba_valid         (rgba_valid),
    .rgba_ready         (rgba_ready),
    .stream_endofpacket (stream_endofpacket),
    .frame_done         (frame_done),
    .frame_error        (frame_error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix(input int i);
    return {8'(3*i+1), 8'(3*i+2), 8'(3*i+3)};
  endfunction

  // Model: a queue of pixels the buffer must hold, plus where we are in the frame
  // counted as a beat index (mode 0 idle, 1 inside a frame, 2 discarding).
  logic [31:0] q[$];
  int          mode = 0;
  int          idx  = 0;
  bit          armed = 0, was_rst = 0, exp_ready = 0;
  bit          exp_done = 0, exp_err = 0, exp_eop = 0;

  int          out_cnt = 0, done_cnt = 0, err_cnt = 0, eop_cnt = 0, acc_cnt = 0;
  logic [31:0] out_log[$];

  always @(negedge clk) begin
    bit nd, ne, neop, frame_pix;
    exp_ready = armed && !was_rst && (q.size() < D);
    if (armed) begin
      check("sink_ready", sink_ready, exp_ready);
      check("rgba_valid", rgba_valid, q.size() != 0);
      if (q.size() != 0) check("rgba_data", rgba_data, q[0]);
      if (was_rst) check("rgba_data_reset", rgba_data, 32'h0);
      check("frame_done", frame_done, exp_done);
      check("frame_error", frame_error, exp_err);
      check("stream_eop", stream_endofpacket, exp_eop);
      if (rgba_valid && rgba_ready) begin
        out_log.push_back(rgba_data);
        out_cnt++;
      end
      done_cnt += int'(frame_done);
      err_cnt  += int'(frame_error);
      eop_cnt  += int'(stream_endofpacket);
    end
    nd = 0; ne = 0; neop = 0; frame_pix = 0;
    if (!reset_reset_n) begin
      q.delete();
      mode    = 0;
      idx     = 0;
      was_rst = 1;
      armed   = 1;
    end else if (armed) begin
      was_rst = 0;
      if (q.size() != 0 && rgba_ready) void'(q.pop_front());
      if (exp_ready && sink_valid) begin
        acc_cnt++;
        neop = sink_endofpacket;
        if (sink_startofpacket) begin
          if (mode == 1) ne = 1;
          idx = 0;
          frame_pix = 1;
        end else if (mode == 1) begin
          frame_pix = 1;
        end else if (mode == 2 && sink_endofpacket) begin
          mode = 0;
        end
        if (frame_pix) begin
          q.push_back({sink_data, ALPHA});
          if (sink_endofpacket) begin
            if (idx == N-1) nd = 1; else ne = 1;
            mode = 0; idx = 0;
          end else if (idx == N-1) begin
            ne = 1; mode = 2; idx = 0;
          end else begin
            idx++; mode = 1;
          end
        end
      end
    end
    exp_done = nd;
    exp_err  = ne;
    exp_eop  = neop;
  end

  task automatic send_beat(input logic [23:0] d, input logic s, input logic e);
    bit got = 0;
    sink_data          = d;
    sink_startofpacket = s;
    sink_endofpacket   = e;
    sink_valid         = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sink_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) check("beat_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    sink_valid         = 1'b0;
    sink_startofpacket = 1'b0;
    sink_endofpacket   = 1'b0;
  endtask

  // n beats from pixel index base; SOP on first if sop, EOP on the last if eop.
  task automatic send_frame(input int n, input int base, input bit sop, input bit eop);
    for (int i = 0; i < n; i++)
      send_beat(pix(base + i), sop && (i == 0), eop && (i == n-1));
  endtask

  task automatic settle();
    repeat (20) @(posedge clk);
    #1;
  endtask

  int o0, d0, e0, p0, a0;
  task automatic mark();
    o0 = out_cnt; d0 = done_cnt; e0 = err_cnt; p0 = eop_cnt; a0 = acc_cnt;
  endtask

  task automatic expect_counts(input string t, input int outs, input int dn, input int er, input int ep);
    check({t, "_outputs"}, out_cnt - o0, outs);
    check({t, "_done"}, done_cnt - d0, dn);
    check({t, "_error"}, err_cnt - e0, er);
    check({t, "_eop"}, eop_cnt - p0, ep);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_reset_n      = 1'b0;
    sink_data          = '0;
    sink_startofpacket = 1'b0;
    sink_endofpacket   = 1'b0;
    sink_valid         = 1'b0;
    rgba_ready         = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_reset_n = 1'b1;
    @(negedge clk);
    check("reset_ready_low", sink_ready, 0);
    check("reset_valid_low", rgba_valid, 0);
    settle();

    // Clean frame, downstream always ready.
    mark();
    send_frame(N, 0, 1, 1);
    settle();
    expect_counts("t1", N, 1, 0, 1);
    check("t1_first_pixel", out_log[o0], 32'h010203FF);
    check("t1_last_pixel", out_log[o0+N-1], 32'h161718FF);

    // Backpressure: buffer fills after four accepts, then drains in order.
    mark();
    rgba_ready = 1'b0;
    fork
      send_frame(N, 0, 1, 1);
      begin
        repeat (12) @(posedge clk);
        #1;
        check("t2_accepts_while_held", acc_cnt - a0, 4);
        check("t2_ready_while_full", sink_ready, 0);
        rgba_ready = 1'b1;
      end
    join
    settle();
    expect_counts("t2", N, 1, 0, 1);
    check("t2_pixel3", out_log[o0+3], 32'h0A0B0CFF);
    check("t2_pixel4", out_log[o0+4], 32'h0D0E0FFF);

    // Short frame: EOP on the fifth beat.
    mark();
    send_frame(5, 0, 1, 1);
    settle();
    expect_counts("t3", 5, 0, 1, 1);

    // Long frame: ten beats, last two discarded while draining.
    mark();
    send_frame(10, 0, 1, 1);
    settle();
    expect_counts("t4", N, 0, 1, 1);
    check("t4_last_kept", out_log[o0+N-1], 32'h161718FF);

    // Leading junk without SOP, then a clean frame.
    mark();
    for (int i = 0; i < 3; i++) send_beat(24'hAAAAAA, 1'b0, 1'b0);
    send_frame(N, 0, 1, 1);
    settle();
    expect_counts("t5", N, 1, 0, 1);
    check("t5_first_pixel", out_log[o0], 32'h010203FF);

    // SOP arriving mid-frame restarts the frame.
    mark();
    send_frame(3, 10, 1, 0);
    send_frame(N, 0, 1, 1);
    settle();
    expect_counts("t7", 3 + N, 1, 1, 1);
    check("t7_old_first", out_log[o0], 32'h1F2021FF);
    check("t7_new_first", out_log[o0+3], 32'h010203FF);

    // Reset with three pixels queued, then a clean frame.
    rgba_ready = 1'b0;
    send_frame(3, 0, 1, 0);
    reset_reset_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("t6_valid_after_reset", rgba_valid, 0);
    reset_reset_n = 1'b1;
    rgba_ready    = 1'b1;
    mark();
    settle();
    send_frame(N, 0, 1, 1);
    settle();
    expect_counts("t6", N, 1, 0, 1);
    check("t6_first_pixel", out_log[o0], 32'h010203FF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/video_stream_sink.md
VIDEO_STREAM_SINK -- requirements
Module: video_stream_sink

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 320, pixels per line.
REQ-002 SHALL have parameter FRAME_HEIGHT, default 240, lines per frame.
REQ-003 SHALL have parameter ALPHA, default 8'hFF, constant alpha byte.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=2).
REQ-005 SHALL have port clk_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset_reset_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port sink_data  in  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 SHALL have port sink_startofpacket  in  1  first beat of frame.
REQ-009 SHALL have port sink_endofpacket  in  1  last beat of frame.
REQ-010 SHALL have port sink_valid  in  1  beat present.
REQ-011 SHALL have port sink_ready  out  1  sink can accept a beat.
REQ-012 SHALL have port rgba_data  out  32  {R,G,B,ALPHA}.
REQ-013 SHALL have port rgba_valid  out  1  rgba_data valid.
REQ-014 SHALL have port rgba_ready  in  1  downstream accepts pixel.
REQ-015 SHALL have port stream_endofpacket  out  1  one-cycle pulse when a frame's EOP beat is accepted.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse, correctly sized frame received.
REQ-017 SHALL have port frame_error  out  1  one-cycle pulse, framing violation.

Function
REQ-018 Beat accepted iff sink_valid && sink_ready; sink_ready SHALL equal !fifo_full (registered, independent of sink_valid).
REQ-019 FSM states WAIT_SOP, RECEIVE, DRAIN.
REQ-020 WAIT_SOP: beats without SOP accepted and discarded; SOP beat written as pixel (0,0) and moves to RECEIVE (or is handled as end of frame if it also carries EOP, per REQ-022/023).
REQ-021 RECEIVE: each accepted beat written to FIFO; x counts 0..FRAME_WIDTH-1 then wraps with y increment; y counts 0..FRAME_HEIGHT-1.
REQ-022 Beat at (W-1,H-1) with EOP: frame_done pulse next cycle, state -> WAIT_SOP, counters cleared.
REQ-023 EOP at any other position: beat still written, frame_error pulse, -> WAIT_SOP.
REQ-024 Beat at (W-1,H-1) without EOP: beat written, frame_error pulse, -> DRAIN.
REQ-025 DRAIN: accepted beats discarded; EOP beat -> WAIT_SOP; SOP beat -> restart as REQ-020.
REQ-026 SOP accepted in RECEIVE: frame_error pulse, beat becomes pixel (0,0) of new frame.
REQ-027 stream_endofpacket SHALL pulse one cycle after any accepted EOP beat, in all states.
REQ-028 Latency: pixel accepted in cycle N visible on rgba_valid in N+1 if FIFO was empty.
REQ-029 rgba_data/rgba_valid SHALL hold stable while rgba_valid && !rgba_ready.
REQ-030 Simultaneous push and pop SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-031 Pixels queued before an error SHALL still be delivered in order.

Reset
REQ-032 While reset_reset_n low at clock edge: state WAIT_SOP, x=y=0, FIFO empty.
REQ-033 Reset values: sink_ready 0 during reset then 1, rgba_valid 0, rgba_data 0, stream_endofpacket 0, frame_done 0, frame_error 0.
REQ-034 Reset mid-frame SHALL discard queued pixels and partial frame with no error pulse.

Structure
REQ-035 Shared package video_stream_pkg SHALL hold FSM state typedef, pixel/RGBA widths (24/32) and byte field offsets.
REQ-036 FIFO SHALL be sub-module video_pixel_fifo (synchronous, show-ahead, full/empty flags).

Verification (bench W=4, H=2, FIFO_DEPTH=4)
REQ-037 8 beats 0x010203..., SOP on 1st, EOP on 8th, rgba_ready=1 -> 8 outputs {0x010203,0xFF}..., frame_done one pulse, no error.
REQ-038 Same frame, rgba_ready=0 -> sink_ready drops after 4 accepts; release -> all 8 delivered in order, no loss/duplication.
REQ-039 EOP on 5th beat -> 5 pixels out, frame_error pulse, stream_endofpacket pulse, no frame_done.
REQ-040 10 beats, EOP on 10th -> 8 pixels out, frame_error after 8th, beats 9-10 dropped, stream_endofpacket after 10th.
REQ-041 3 non-SOP beats then valid frame -> first 3 dropped, frame output as REQ-037.
REQ-042 Reset asserted after 3rd beat -> rgba_valid 0 next cycle, following valid frame received cleanly.
